// File: rtl/div_radix2_pkg.sv
// Shared constants for the execute-stage divider: default widths and the ALU
// control codes that select DIV / DIVU in the decoder.
package div_radix2_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
    localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == DIV_CONTROL) || (aluop == DIVU_CONTROL);
    endfunction

    function automatic logic is_signed_div_op(input logic [7:0] aluop);
        return aluop == DIV_CONTROL;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Works on magnitudes and
// fixes signs in a final cycle; returns {remainder, quotient} with a one-cycle ready.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_DIVZERO = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;
    localparam int         DIV_ITER  = WIDTH;

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic en);
        return (en && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 neg_quot_q, neg_quot_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    // Two extra bits so the borrow of the trial subtract is visible directly.
    logic [WIDTH:0]       shifted_rem;
    logic [WIDTH+1:0]     trial;
    logic                 trial_neg;

    assign shifted_rem = {rem_q, dvd_q[WIDTH-1]};
    assign trial       = {1'b0, shifted_rem} - {2'b00, dsr_q};
    assign trial_neg   = trial[WIDTH+1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !annul)
                    state_d = (opdata2 == '0) ? S_DIVZERO : S_BUSY;
            end
            S_BUSY: begin
                if (annul || !start)
                    state_d = S_IDLE;
                else if (cnt_q == CNT_W'(DIV_ITER))
                    state_d = S_DONE;
            end
            S_DIVZERO: begin
                state_d = (annul || !start) ? S_IDLE : S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = (state_d == S_DONE);

        if (state_q == S_IDLE && start && !annul) begin
            dvd_d      = abs_w(opdata1, signed_div);
            dsr_d      = abs_w(opdata2, signed_div);
            rem_d      = '0;
            cnt_d      = '0;
            neg_quot_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_rem_d  = signed_div & opdata1[WIDTH-1];
        end else if (state_d == S_BUSY && state_q == S_BUSY) begin
            // dvd_q doubles as the quotient: dividend bits leave the top as quotient bits enter the bottom.
            rem_d = trial_neg ? shifted_rem[WIDTH-1:0] : trial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], ~trial_neg};
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_d == S_DONE) begin
            if (state_q == S_DIVZERO)
                // Re-applying the dividend sign restores the original opdata1.
                result_d = {neg_if(dvd_q, neg_rem_q), {WIDTH{1'b1}}};
            else
                result_d = {neg_if(rem_q, neg_rem_q), neg_if(dvd_q, neg_quot_q)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed corner cases, aborts, async reset
// and randomized DIV/DIVU checked against plain integer arithmetic.
module tb_div_radix2;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_checks;
    int n_fail;
    logic [63:0] held_result;

    div_radix2 dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: truncating integer division; signed cases done in 64-bit so
    // the most-negative / -1 case simply wraps when cut back to 32 bits.
    function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat;
        bit seen;
        exp = ref_div(sd, a, b);
        @(negedge clk);
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready) seen = 1;
        end
        chk("latency", 64'(lat), (b == 32'd0) ? 64'd2 : 64'd34);
        chk("result", result, exp);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("single_pulse", {63'd0, ready}, 64'd0);
        chk("result_hold", result, exp);
        held_result = exp;
        $display("op %s a=%h b=%h result=%h latency=%0d", sd ? "DIV " : "DIVU", a, b, result, lat);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ready) pulses++;
        end
        chk({tag, "_no_ready"}, 64'(pulses), 64'd0);
        chk({tag, "_result_kept"}, result, held_result);
        $display("abort %s result=%h pulses=%0d", tag, result, pulses);
    endtask

    initial begin
        logic        sd;
        logic [31:0] a, b;
        n_checks    = 0;
        n_fail      = 0;
        held_result = '0;
        rst         = 1'b1;
        signed_div  = 1'b0;
        opdata1     = '0;
        opdata2     = '0;
        start       = 1'b0;
        annul       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_div(1'b0, 32'd100, 32'd7);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1);
        do_div(1'b0, 32'd5, 32'd0);
        do_div(1'b0, 32'd3, 32'd10);

        // annul pulsed at iteration 10 while start is still held
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        watch_quiet("annul_busy", 40);
        do_div(1'b0, 32'd9, 32'd3);

        // annul together with start in IDLE
        @(negedge clk);
        opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        watch_quiet("annul_idle", 40);

        // start withdrawn mid-BUSY and mid-DIVZERO
        @(negedge clk);
        opdata1 = 32'd77; opdata2 = 32'd4; start = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        watch_quiet("start_drop", 40);
        @(negedge clk);
        opdata1 = 32'd77; opdata2 = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch_quiet("start_drop_dz", 10);

        // back-to-back: second start raised the cycle after ready
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE);

        // async reset in the middle of BUSY
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd12345; opdata2 = 32'd11; start = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", {63'd0, ready}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        $display("async reset result=%h ready=%0d", result, ready);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        held_result = '0;
        watch_quiet("after_rst", 5);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(1, 20));
                1:       b = $urandom;
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (b == 32'd0) b = 32'd1;
            if (!sd && $urandom_range(0, 15) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            do_div(sd, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
